// File: rtl/change_dispense_controller.sv
// change_dispense_controller
// Vending-machine change controller. Accepts one-hot coins, vends one-hot
// selected items against the registered balance, and returns change
// greedily (1000 / 500 / 100) either on request or after an idle timeout.
//
// Ports:
//   clk               single clock, all state updates on rising edge
//   reset_n           asynchronous reset, active HIGH (1 = in reset)
//   i_input_coin      one-hot coin: bit0 = 100, bit1 = 500, bit2 = 1000
//   i_select_item     one-hot item: bit0 = 400, bit1 = 500, bit2 = 1000, bit3 = 2000
//   i_trigger_return  request immediate change return
//   o_available_item  bit i set when the balance covers price[i] (0 in RETURN)
//   o_output_item     one-cycle pulse for the vended item
//   o_return_coin     one-hot coin dispensed this cycle
//   o_coin_reject     one-cycle pulse when an inserted coin is refused
//   o_current_total   registered balance
//   o_wait_time       registered remaining idle cycles before auto-return
//   o_busy            high while dispensing change
module change_dispense_controller #(
  parameter int kWaitCycles = 100,
  parameter int kMaxTotal   = 9900
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  i_input_coin,
  input  logic [3:0]  i_select_item,
  input  logic        i_trigger_return,
  output logic [3:0]  o_available_item,
  output logic [3:0]  o_output_item,
  output logic [2:0]  o_return_coin,
  output logic        o_coin_reject,
  output logic [15:0] o_current_total,
  output logic [31:0] o_wait_time,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RETURN
  } state_t;

  localparam logic [16:0] kMaxTotal17 = 17'(kMaxTotal);
  localparam logic [31:0] kWaitLoad   = 32'(kWaitCycles);

  state_t      state_q, state_d;
  logic [15:0] balance_q, balance_d;
  logic [31:0] wait_q, wait_d;
  logic [3:0]  item_q, item_d;
  logic [2:0]  coin_q, coin_d;
  logic        reject_q, reject_d;

  logic        coin_valid, sel_valid, coin_ok, vend_ok;
  logic [15:0] coin_value, price, post_balance;
  logic [16:0] sum_with_coin;

  // Decode the one-hot inputs; zero or multi-hot patterns decode as invalid
  always_comb begin
    coin_valid = 1'b1;
    coin_value = 16'd0;
    case (i_input_coin)
      3'b001:  coin_value = 16'd100;
      3'b010:  coin_value = 16'd500;
      3'b100:  coin_value = 16'd1000;
      default: coin_valid = 1'b0;
    endcase

    sel_valid = 1'b1;
    price     = 16'd0;
    case (i_select_item)
      4'b0001: price = 16'd400;
      4'b0010: price = 16'd500;
      4'b0100: price = 16'd1000;
      4'b1000: price = 16'd2000;
      default: sel_valid = 1'b0;
    endcase
  end

  // The coin limit check is done one bit wider so a large balance cannot wrap.
  // The vend uses only the registered balance, so the 16-bit post-update
  // balance can never underflow and never exceeds kMaxTotal.
  assign sum_with_coin = {1'b0, balance_q} + {1'b0, coin_value};
  assign coin_ok       = coin_valid && (sum_with_coin <= kMaxTotal17);
  assign vend_ok       = sel_valid && (balance_q >= price);
  assign post_balance  = balance_q + (coin_ok ? coin_value : 16'd0)
                                   - (vend_ok ? price : 16'd0);

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    balance_d = balance_q;
    wait_d    = wait_q;
    item_d    = 4'b0000;
    coin_d    = 3'b000;
    reject_d  = 1'b0;

    if (state_q == ST_RETURN) begin
      // Inputs other than coins are ignored; coins are refused while paying out.
      // The final coin is shown for one cycle before dropping back to IDLE.
      reject_d = coin_valid;
      wait_d   = 32'd0;
      if (balance_q == 16'd0) begin
        state_d = ST_IDLE;
      end else if (balance_q >= 16'd1000) begin
        coin_d    = 3'b100;
        balance_d = balance_q - 16'd1000;
      end else if (balance_q >= 16'd500) begin
        coin_d    = 3'b010;
        balance_d = balance_q - 16'd500;
      end else begin
        coin_d    = 3'b001;
        balance_d = balance_q - 16'd100;
      end
    end else begin
      reject_d  = coin_valid && !coin_ok;
      item_d    = vend_ok ? i_select_item : 4'b0000;
      balance_d = post_balance;

      if (post_balance == 16'd0) begin
        state_d = ST_IDLE;
        wait_d  = 32'd0;
      end else if (i_trigger_return) begin
        state_d = ST_RETURN;
        wait_d  = 32'd0;
      end else if (coin_ok || vend_ok) begin
        state_d = ST_ACTIVE;
        wait_d  = kWaitLoad;
      end else if (wait_q <= 32'd1) begin
        // Timer expires: RETURN starts in the same cycle the count reads 0
        state_d = ST_RETURN;
        wait_d  = 32'd0;
      end else begin
        state_d = ST_ACTIVE;
        wait_d  = wait_q - 32'd1;
      end
    end
  end

  // State and registered outputs; reset discards any undispensed balance
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q   <= ST_IDLE;
      balance_q <= 16'd0;
      wait_q    <= 32'd0;
      item_q    <= 4'b0000;
      coin_q    <= 3'b000;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      balance_q <= balance_d;
      wait_q    <= wait_d;
      item_q    <= item_d;
      coin_q    <= coin_d;
      reject_q  <= reject_d;
    end
  end

  // Availability follows the registered balance and is blanked while paying out
  always_comb begin
    o_available_item = 4'b0000;
    if (state_q != ST_RETURN) begin
      o_available_item = {balance_q >= 16'd2000, balance_q >= 16'd1000,
                          balance_q >= 16'd500,  balance_q >= 16'd400};
    end
  end

  assign o_output_item   = item_q;
  assign o_return_coin   = coin_q;
  assign o_coin_reject   = reject_q;
  assign o_current_total = balance_q;
  assign o_wait_time     = wait_q;
  assign o_busy          = (state_q == ST_RETURN);

endmodule

// File: tb/tb_change_dispense_controller.sv
// tb_change_dispense_controller
// Directed scoreboard bench for change_dispense_controller. Each stimulus
// call is preceded by pushes of the values expected after the next clock
// edge; those are popped and compared once the edge has passed.
module tb_change_dispense_controller;

  localparam int K_TOTAL = 0;
  localparam int K_WAIT  = 1;
  localparam int K_ITEM  = 2;
  localparam int K_COIN  = 3;
  localparam int K_REJ   = 4;
  localparam int K_BUSY  = 5;
  localparam int K_AVAIL = 6;

  logic        clk;
  logic        reset_n;
  logic [2:0]  i_input_coin;
  logic [3:0]  i_select_item;
  logic        i_trigger_return;
  logic [3:0]  o_available_item;
  logic [3:0]  o_output_item;
  logic [2:0]  o_return_coin;
  logic        o_coin_reject;
  logic [15:0] o_current_total;
  logic [31:0] o_wait_time;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] value;
  } exp_t;

  exp_t scoreboard[$];

  logic [2:0] trig_coins [4] = '{3'b100, 3'b010, 3'b001, 3'b001};
  int         trig_totals[4] = '{700, 200, 100, 0};

  change_dispense_controller #(
    .kWaitCycles(100),
    .kMaxTotal(9900)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_input_coin(i_input_coin),
    .i_select_item(i_select_item),
    .i_trigger_return(i_trigger_return),
    .o_available_item(o_available_item),
    .o_output_item(o_output_item),
    .o_return_coin(o_return_coin),
    .o_coin_reject(o_coin_reject),
    .o_current_total(o_current_total),
    .o_wait_time(o_wait_time),
    .o_busy(o_busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, observed running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expectOut(input string tag, input int kind, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.kind  = kind;
    e.value = value;
    scoreboard.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_TOTAL: return {16'd0, o_current_total};
      K_WAIT:  return o_wait_time;
      K_ITEM:  return {28'd0, o_output_item};
      K_COIN:  return {29'd0, o_return_coin};
      K_REJ:   return {31'd0, o_coin_reject};
      K_BUSY:  return {31'd0, o_busy};
      K_AVAIL: return {28'd0, o_available_item};
      default: return 32'hdeadbeef;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic drainScoreboard();
    exp_t e;
    while (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      checkOutput(e.tag, observe(e.kind), e.value);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, then check queued expectations
  task automatic applyStimulus(input logic [2:0] coin, input logic [3:0] sel,
                               input logic trig);
    i_input_coin     = coin;
    i_select_item    = sel;
    i_trigger_return = trig;
    @(posedge clk);
    #1;
    i_input_coin     = 3'b000;
    i_select_item    = 4'b0000;
    i_trigger_return = 1'b0;
    drainScoreboard();
  endtask

  task automatic expectAllZero(input string tag);
    expectOut({tag, "_total"}, K_TOTAL, 0);
    expectOut({tag, "_wait"},  K_WAIT,  0);
    expectOut({tag, "_item"},  K_ITEM,  0);
    expectOut({tag, "_coin"},  K_COIN,  0);
    expectOut({tag, "_rej"},   K_REJ,   0);
    expectOut({tag, "_busy"},  K_BUSY,  0);
    expectOut({tag, "_avail"}, K_AVAIL, 0);
  endtask

  initial begin
    reset_n          = 1'b1;
    i_input_coin     = 3'b000;
    i_select_item    = 4'b0000;
    i_trigger_return = 1'b0;

    // Reset state
    #2;
    expectAllZero("reset");
    drainScoreboard();
    #10;
    reset_n = 1'b0;
    $display("[TB] reset released");

    // Buy: 500 + 100, multi-hot select ignored, buy the 400 item
    expectOut("buy_total500", K_TOTAL, 500);
    expectOut("buy_wait500",  K_WAIT,  100);
    expectOut("buy_avail500", K_AVAIL, 4'b0011);
    applyStimulus(3'b010, 4'b0000, 1'b0);
    expectOut("buy_total600", K_TOTAL, 600);
    expectOut("buy_avail600", K_AVAIL, 4'b0011);
    applyStimulus(3'b001, 4'b0000, 1'b0);
    expectOut("buy_multisel_item",  K_ITEM,  4'b0000);
    expectOut("buy_multisel_total", K_TOTAL, 600);
    expectOut("buy_multisel_wait",  K_WAIT,  99);
    applyStimulus(3'b000, 4'b0011, 1'b0);
    expectOut("buy_item",  K_ITEM,  4'b0001);
    expectOut("buy_total", K_TOTAL, 200);
    expectOut("buy_wait",  K_WAIT,  100);
    expectOut("buy_avail", K_AVAIL, 4'b0000);
    applyStimulus(3'b000, 4'b0001, 1'b0);
    expectOut("buy_item_pulse_end", K_ITEM, 4'b0000);
    expectOut("buy_wait_dec",       K_WAIT, 99);
    applyStimulus(3'b000, 4'b0000, 1'b0);
    expectOut("buy_trig_busy",  K_BUSY,  1);
    expectOut("buy_trig_wait",  K_WAIT,  0);
    expectOut("buy_trig_total", K_TOTAL, 200);
    expectOut("buy_trig_coin",  K_COIN,  3'b000);
    applyStimulus(3'b000, 4'b0000, 1'b1);
    expectOut("buy_ret1_coin",  K_COIN,  3'b001);
    expectOut("buy_ret1_total", K_TOTAL, 100);
    applyStimulus(3'b000, 4'b0000, 1'b0);
    expectOut("buy_ret2_coin",  K_COIN,  3'b001);
    expectOut("buy_ret2_total", K_TOTAL, 0);
    expectOut("buy_ret2_busy",  K_BUSY,  1);
    applyStimulus(3'b000, 4'b0000, 1'b0);
    expectOut("buy_idle_coin", K_COIN, 3'b000);
    expectOut("buy_idle_busy", K_BUSY, 0);
    applyStimulus(3'b000, 4'b0000, 1'b0);
    expectOut("zero_trig_busy", K_BUSY, 0);
    expectOut("zero_trig_wait", K_WAIT, 0);
    applyStimulus(3'b000, 4'b0000, 1'b1);

    // Timeout: 1000 + 500, then wait out the timer
    expectOut("to_total1000", K_TOTAL, 1000);
    expectOut("to_avail1000", K_AVAIL, 4'b0111);
    applyStimulus(3'b100, 4'b0000, 1'b0);
    expectOut("to_total1500", K_TOTAL, 1500);
    expectOut("to_wait1500",  K_WAIT,  100);
    applyStimulus(3'b010, 4'b0000, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      expectOut("to_wait", K_WAIT, 32'(100 - k));
      expectOut("to_busy", K_BUSY, (k == 100) ? 32'd1 : 32'd0);
      applyStimulus(3'b000, 4'b0000, 1'b0);
    end
    expectOut("to_ret_avail", K_AVAIL, 4'b0000);
    expectOut("to_ret1_coin", K_COIN,  3'b100);
    expectOut("to_ret1_total", K_TOTAL, 500);
    applyStimulus(3'b000, 4'b0000, 1'b0);
    expectOut("to_ret2_coin",  K_COIN,  3'b010);
    expectOut("to_ret2_total", K_TOTAL, 0);
    applyStimulus(3'b000, 4'b0000, 1'b0);
    expectOut("to_idle_busy", K_BUSY, 0);
    expectOut("to_idle_coin", K_COIN, 3'b000);
    applyStimulus(3'b000, 4'b0000, 1'b0);

    // Trigger: build 1700 and request return
    expectOut("tr_total1000", K_TOTAL, 1000);
    applyStimulus(3'b100, 4'b0000, 1'b0);
    expectOut("tr_total1500", K_TOTAL, 1500);
    applyStimulus(3'b010, 4'b0000, 1'b0);
    expectOut("tr_total1600", K_TOTAL, 1600);
    applyStimulus(3'b001, 4'b0000, 1'b0);
    expectOut("tr_total1700", K_TOTAL, 1700);
    expectOut("tr_avail1700", K_AVAIL, 4'b0111);
    applyStimulus(3'b001, 4'b0000, 1'b0);
    expectOut("tr_busy",  K_BUSY,  1);
    expectOut("tr_wait",  K_WAIT,  0);
    expectOut("tr_total", K_TOTAL, 1700);
    applyStimulus(3'b000, 4'b0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      expectOut("tr_coin",      K_COIN,  {29'd0, trig_coins[k]});
      expectOut("tr_ret_total", K_TOTAL, 32'(trig_totals[k]));
      applyStimulus(3'b000, 4'b0000, 1'b0);
    end
    expectOut("tr_idle_busy", K_BUSY, 0);
    applyStimulus(3'b000, 4'b0000, 1'b0);

    // Simultaneous coin and vend at 400, then a coin during RETURN
    for (int k = 1; k <= 4; k++) begin
      expectOut("sim_build", K_TOTAL, 32'(100 * k));
      applyStimulus(3'b001, 4'b0000, 1'b0);
    end
    expectOut("sim_item",  K_ITEM,  4'b0001);
    expectOut("sim_total", K_TOTAL, 100);
    expectOut("sim_wait",  K_WAIT,  100);
    applyStimulus(3'b001, 4'b0001, 1'b0);
    expectOut("sim_poor_item",  K_ITEM,  4'b0000);
    expectOut("sim_poor_total", K_TOTAL, 100);
    expectOut("sim_poor_wait",  K_WAIT,  99);
    applyStimulus(3'b000, 4'b0010, 1'b0);
    expectOut("sim_trig_busy", K_BUSY, 1);
    applyStimulus(3'b000, 4'b0000, 1'b1);
    expectOut("sim_ret_rej",   K_REJ,   1);
    expectOut("sim_ret_coin",  K_COIN,  3'b001);
    expectOut("sim_ret_total", K_TOTAL, 0);
    applyStimulus(3'b010, 4'b0000, 1'b0);
    expectOut("sim_idle_rej",  K_REJ,   0);
    expectOut("sim_idle_busy", K_BUSY,  0);
    expectOut("sim_idle_total", K_TOTAL, 0);
    applyStimulus(3'b000, 4'b0000, 1'b0);

    // Overflow and multi-hot coin handling near kMaxTotal
    for (int k = 1; k <= 9; k++) begin
      expectOut("ov_build", K_TOTAL, 32'(1000 * k));
      applyStimulus(3'b100, 4'b0000, 1'b0);
    end
    expectOut("ov_total9500", K_TOTAL, 9500);
    applyStimulus(3'b010, 4'b0000, 1'b0);
    expectOut("ov_rej",       K_REJ,   1);
    expectOut("ov_rej_total", K_TOTAL, 9500);
    expectOut("ov_rej_wait",  K_WAIT,  99);
    applyStimulus(3'b010, 4'b0000, 1'b0);
    expectOut("ov_multi_rej",   K_REJ,   0);
    expectOut("ov_multi_total", K_TOTAL, 9500);
    applyStimulus(3'b011, 4'b0000, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      expectOut("ov_fill",     K_TOTAL, 32'(9500 + 100 * k));
      expectOut("ov_fill_rej", K_REJ,   0);
      applyStimulus(3'b001, 4'b0000, 1'b0);
    end
    expectOut("ov_max_rej",   K_REJ,   1);
    expectOut("ov_max_total", K_TOTAL, 9900);
    applyStimulus(3'b001, 4'b0000, 1'b0);
    expectOut("ov_vend_item",  K_ITEM,  4'b1000);
    expectOut("ov_vend_total", K_TOTAL, 7900);
    applyStimulus(3'b000, 4'b1000, 1'b0);

    // Reset asserted between edges in the middle of RETURN
    expectOut("rst_trig_busy", K_BUSY, 1);
    applyStimulus(3'b000, 4'b0000, 1'b1);
    expectOut("rst_ret_coin",  K_COIN,  3'b100);
    expectOut("rst_ret_total", K_TOTAL, 6900);
    applyStimulus(3'b000, 4'b0000, 1'b0);
    #2;
    reset_n = 1'b1;
    #1;
    expectAllZero("rst_async");
    drainScoreboard();
    for (int k = 0; k < 2; k++) begin
      expectOut("rst_hold_total", K_TOTAL, 0);
      expectOut("rst_hold_busy",  K_BUSY,  0);
      applyStimulus(3'b001, 4'b0000, 1'b0);
    end
    #2;
    reset_n = 1'b0;
    expectOut("rst_first_total", K_TOTAL, 100);
    expectOut("rst_first_wait",  K_WAIT,  100);
    expectOut("rst_first_busy",  K_BUSY,  0);
    applyStimulus(3'b001, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
